m_led_pwm: RTL

Four-channel LED brightness stage between the free-running pattern counter and the board LED pins. Takes a 4-bit on/off pattern and an 8-bit global brightness. Drives each LED with a glitch-free PWM waveform. Optionally fades each channel linearly up or down when its pattern bit changes.

---
 rtl/m_led_pwm_pkg.sv | 20 ++
 rtl/m_led_pwm_ch.sv | 74 +++++++
 rtl/m_led_pwm.sv | 89 ++++++++
 3 files changed

// File: rtl/m_led_pwm_pkg.sv
// Shared definitions for the LED PWM stage.
// Provides the channel count, the default PWM width, the per-channel fade
// state type and a counter-width helper used to size the free-running dividers.
package m_led_pwm_pkg;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned PWM_BITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ch_state_e;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_led_pwm_ch.sv
// One LED channel: brightness level register, fade state and PWM comparator.
// Ports:
//   w_clk, w_rst     clock and synchronous active-high reset
//   w_pat            requested on/off for this LED
//   w_duty           brightness that applies from the current boundary on
//   w_cnt            shared PWM counter
//   w_period_end     last cycle of a PWM period (level update point)
//   w_fade_step      period end on which a fading level may move by one
//   w_fade_en        1 = ramp toward target, 0 = jump to target
//   w_led            registered PWM output
module m_led_pwm_ch
    import m_led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic                w_pat,
    input  logic [PWM_BITS-1:0] w_duty,
    input  logic [PWM_BITS-1:0] w_cnt,
    input  logic                w_period_end,
    input  logic                w_fade_step,
    input  logic                w_fade_en,
    output logic                w_led
);

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] r_lvl;
    logic [PWM_BITS-1:0] w_lvl_nxt;
    logic [PWM_BITS-1:0] w_tgt;
    ch_state_e           r_state;
    ch_state_e           w_state_nxt;
    logic                r_led;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_lvl   <= '0;
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
        end else begin
            r_lvl   <= w_lvl_nxt;
            r_state <= w_state_nxt;
            r_led   <= (r_lvl > w_cnt);
        end
    end

    // Direction is recomputed from level vs. target on every step, so a
    // reversed pattern or new duty simply turns the ramp around in place.
    always_comb begin
        w_tgt       = w_pat ? w_duty : '0;
        w_lvl_nxt   = r_lvl;
        w_state_nxt = r_state;
        if (w_period_end) begin
            if (!w_fade_en) begin
                w_lvl_nxt   = w_tgt;
                w_state_nxt = ST_IDLE;
            end else if (w_fade_step) begin
                if (r_lvl < w_tgt) begin
                    w_lvl_nxt   = r_lvl + ONE;
                    w_state_nxt = (w_lvl_nxt == w_tgt) ? ST_IDLE : ST_UP;
                end else if (r_lvl > w_tgt) begin
                    w_lvl_nxt   = r_lvl - ONE;
                    w_state_nxt = (w_lvl_nxt == w_tgt) ? ST_IDLE : ST_DOWN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign w_led = r_led;

endmodule

// File: rtl/m_led_pwm.sv
// Four-channel LED brightness stage with glitch-free PWM and optional fading.
// Ports:
//   w_clk, w_rst   clock and synchronous active-high reset
//   w_pat          requested on/off pattern, one bit per LED
//   w_duty         global brightness, captured on w_duty_we
//   w_duty_we      single-cycle write strobe for w_duty
//   w_fade_en      1 = ramp levels, 0 = jump levels
//   w_led          registered PWM outputs
module m_led_pwm
    import m_led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE     = 100,
    parameter int unsigned PWM_BITS     = PWM_BITS_DEF,
    parameter int unsigned FADE_PERIODS = 4,
    parameter int unsigned DUTY_INIT    = 128
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic [NUM_CH-1:0]   w_pat,
    input  logic [PWM_BITS-1:0] w_duty,
    input  logic                w_duty_we,
    input  logic                w_fade_en,
    output logic [NUM_CH-1:0]   w_led
);

    localparam int unsigned PRE_W  = cnt_width(PRESCALE);
    localparam int unsigned FDIV_W = cnt_width(FADE_PERIODS);

    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [FDIV_W-1:0]   FDIV_MAX = FDIV_W'(FADE_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_RST = PWM_BITS'(DUTY_INIT);

    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_cnt;
    logic [FDIV_W-1:0]   r_fdiv;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_duty_pend;
    logic [PWM_BITS-1:0] w_duty_cur;
    logic                w_tick;
    logic                w_period_end;
    logic                w_fade_step;

    assign w_tick       = (r_pre == PRE_MAX);
    assign w_period_end = w_tick && (r_cnt == '1);
    assign w_fade_step  = w_period_end && (r_fdiv == FDIV_MAX);

    // At a boundary the channels must see the duty that takes effect there,
    // which is the pending value r_duty is about to load.
    assign w_duty_cur = w_period_end ? r_duty_pend : r_duty;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pre       <= '0;
            r_cnt       <= '0;
            r_fdiv      <= '0;
            r_duty      <= DUTY_RST;
            r_duty_pend <= DUTY_RST;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + PWM_BITS'(1);
            end
            if (w_period_end) begin
                r_fdiv <= (r_fdiv == FDIV_MAX) ? '0 : r_fdiv + FDIV_W'(1);
                r_duty <= r_duty_pend;
            end
            if (w_duty_we) begin
                r_duty_pend <= w_duty;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        m_led_pwm_ch #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .w_clk       (w_clk),
            .w_rst       (w_rst),
            .w_pat       (w_pat[g]),
            .w_duty      (w_duty_cur),
            .w_cnt       (r_cnt),
            .w_period_end(w_period_end),
            .w_fade_step (w_fade_step),
            .w_fade_en   (w_fade_en),
            .w_led       (w_led[g])
        );
    end

endmodule
